// File: rtl/cluster_frame_tx_pkg.sv
// Shared constants, state codes and hit-word layout for the cluster frame transmitter.
// The hit word packs a presence flag above the raw x/y coordinates.
package cluster_frame_tx_pkg;

  localparam logic [15:0] SYNC_WORD = 16'hAAAA;
  localparam int          NCH       = 16;
  localparam int          NBEAT     = 16;
  localparam int          MAX_HITS  = 256;

  localparam int HW_W     = 13;
  localparam int HW_C_BIT = 12;
  localparam int HW_X_MSB = 11;
  localparam int HW_X_LSB = 6;
  localparam int HW_Y_MSB = 5;
  localparam int HW_Y_LSB = 0;

  typedef logic [2:0]      state_t;
  typedef logic [HW_W-1:0] hit_word_t;

  localparam state_t ST_COLLECT = 3'd0;
  localparam state_t ST_SYNC    = 3'd1;
  localparam state_t ST_DATA    = 3'd2;
  localparam state_t ST_TRAIL   = 3'd3;
  localparam state_t ST_GAP     = 3'd4;

  // Coordinates go out unmodified; the receiver applies the +1 offset.
  function automatic hit_word_t make_hit_word(input logic [5:0] x, input logic [5:0] y);
    hit_word_t w;
    w                    = '0;
    w[HW_C_BIT]          = 1'b1;
    w[HW_X_MSB:HW_X_LSB] = x;
    w[HW_Y_MSB:HW_Y_LSB] = y;
    return w;
  endfunction

endpackage

// File: rtl/cluster_frame_tx_hit_slot_bank.sv
// 16 channel banks x 16 beat entries of hit words, with per-slot valid bits.
// Slot n lives in bank n mod 16 at entry n div 16; reads return zero for empty slots.
module hit_slot_bank
  import cluster_frame_tx_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clr,
  input  logic                       i_we,
  input  logic [7:0]                 i_waddr,
  input  hit_word_t                  i_wdata,
  input  logic [3:0]                 i_rbeat,
  output logic [NCH-1:0][HW_W-1:0]   o_rdata
);

  hit_word_t        r_mem [NCH][NBEAT];
  logic [NCH-1:0]   r_vld [NBEAT];

  // Data storage carries no reset; the valid bits alone decide what is visible.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr[3:0]][i_waddr[7:4]] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      for (int b = 0; b < NBEAT; b++) begin
        r_vld[b] <= '0;
      end
    end else if (i_we) begin
      r_vld[i_waddr[7:4]][i_waddr[3:0]] <= 1'b1;
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int c = 0; c < NCH; c++) begin
      o_rdata[c] = r_vld[i_rbeat][c] ? r_mem[c][i_rbeat] : '0;
    end
  end

endmodule

// File: rtl/cluster_frame_tx.sv
// Collects a hit stream per event and emits it as a framed burst:
// SYNC word, 16 data beats across 16 channels, event-id trailer, then an idle gap.
module cluster_frame_tx
  import cluster_frame_tx_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [5:0]  s_x,
  input  logic [5:0]  s_y,
  input  logic        s_null,
  input  logic        s_last,
  input  logic [9:0]  s_evt_id,
  output logic [15:0] fiber,
  output logic [15:0] fxch00,
  output logic [15:0] fxch01,
  output logic [15:0] fxch02,
  output logic [15:0] fxch03,
  output logic [15:0] fxch04,
  output logic [15:0] fxch05,
  output logic [15:0] fxch06,
  output logic [15:0] fxch07,
  output logic [15:0] fxch08,
  output logic [15:0] fxch09,
  output logic [15:0] fxch10,
  output logic [15:0] fxch11,
  output logic [15:0] fxch12,
  output logic [15:0] fxch13,
  output logic [15:0] fxch14,
  output logic [15:0] fxch15,
  output logic        ovf,
  output state_t      dbg_state
);

  // Handshake: a beat transfers on a rising edge where s_valid and s_ready are
  // both high; s_ready is high exactly while the FSM sits in COLLECT.

  state_t       r_state;
  state_t       w_nstate;
  logic [3:0]   r_beat;
  logic [3:0]   r_gap;
  logic [8:0]   r_cnt;
  logic [9:0]   r_evt;
  logic         r_s_ready;
  logic [15:0]  r_fiber;
  logic [15:0]  r_fxch [NCH];
  logic         r_ovf;

  logic                     w_accept;
  logic                     w_hit;
  logic                     w_full;
  logic                     w_store;
  logic                     w_drop;
  logic [3:0]               w_rbeat;
  logic [NCH-1:0][HW_W-1:0] w_rdata;

  assign w_accept = s_valid && r_s_ready && (r_state == ST_COLLECT);
  assign w_hit    = w_accept && !s_null;
  assign w_full   = (r_cnt == 9'(MAX_HITS));
  assign w_store  = w_hit && !w_full;
  assign w_drop   = w_hit && w_full;

  // The read address leads the output register by one beat.
  assign w_rbeat  = (r_state == ST_DATA) ? (r_beat + 4'd1) : 4'd0;

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      ST_COLLECT: if (w_accept && s_last) w_nstate = ST_SYNC;
      ST_SYNC:    w_nstate = ST_DATA;
      ST_DATA:    if (r_beat == 4'(NBEAT - 1)) w_nstate = ST_TRAIL;
      ST_TRAIL:   w_nstate = ST_GAP;
      ST_GAP:     if (r_gap == 4'(GAP_CYCLES - 1)) w_nstate = ST_COLLECT;
      default:    w_nstate = ST_COLLECT;
    endcase
  end

  hit_slot_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (r_state == ST_GAP),
    .i_we    (w_store),
    .i_waddr (r_cnt[7:0]),
    .i_wdata (make_hit_word(s_x, s_y)),
    .i_rbeat (w_rbeat),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_COLLECT;
      r_beat    <= '0;
      r_gap     <= '0;
      r_cnt     <= '0;
      r_evt     <= '0;
      r_s_ready <= 1'b1;
      r_fiber   <= '0;
      r_ovf     <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        r_fxch[c] <= '0;
      end
    end else begin
      r_state   <= w_nstate;
      r_s_ready <= (w_nstate == ST_COLLECT);
      r_ovf     <= w_drop;
      r_beat    <= (r_state == ST_DATA) ? r_beat + 4'd1 : 4'd0;
      r_gap     <= (r_state == ST_GAP) ? r_gap + 4'd1 : 4'd0;

      if (r_state == ST_GAP) begin
        r_cnt <= '0;
      end else if (w_store) begin
        r_cnt <= r_cnt + 9'd1;
      end

      if (w_accept && s_last) begin
        r_evt <= s_evt_id;
      end

      // Outputs are decoded from the next state so they line up with it.
      if (w_nstate == ST_SYNC) begin
        r_fiber <= SYNC_WORD;
      end else if (w_nstate == ST_TRAIL) begin
        r_fiber <= {6'b0, r_evt};
      end else begin
        r_fiber <= '0;
      end

      for (int c = 0; c < NCH; c++) begin
        r_fxch[c] <= (w_nstate == ST_DATA) ? {3'b000, w_rdata[c]} : 16'h0000;
      end
    end
  end

  assign s_ready   = r_s_ready;
  assign fiber     = r_fiber;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

  assign fxch00 = r_fxch[0];
  assign fxch01 = r_fxch[1];
  assign fxch02 = r_fxch[2];
  assign fxch03 = r_fxch[3];
  assign fxch04 = r_fxch[4];
  assign fxch05 = r_fxch[5];
  assign fxch06 = r_fxch[6];
  assign fxch07 = r_fxch[7];
  assign fxch08 = r_fxch[8];
  assign fxch09 = r_fxch[9];
  assign fxch10 = r_fxch[10];
  assign fxch11 = r_fxch[11];
  assign fxch12 = r_fxch[12];
  assign fxch13 = r_fxch[13];
  assign fxch14 = r_fxch[14];
  assign fxch15 = r_fxch[15];

endmodule

// File: tb/tb_cluster_frame_tx.sv
// Bench for cluster_frame_tx: events are built as beat lists, the expected frame is
// derived from the list of hits in arrival order and compared cycle by cycle.
module tb_cluster_frame_tx;

  localparam int GAP = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [5:0]  s_x;
  logic [5:0]  s_y;
  logic        s_null;
  logic        s_last;
  logic [9:0]  s_evt_id;
  logic [15:0] fiber;
  logic [15:0] fxch00, fxch01, fxch02, fxch03, fxch04, fxch05, fxch06, fxch07;
  logic [15:0] fxch08, fxch09, fxch10, fxch11, fxch12, fxch13, fxch14, fxch15;
  logic        ovf;
  logic [2:0]  dbg_state;
  logic [15:0] fx [16];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ovf_seen = 0;
  int not_ready_cnt;
  int last_sync_cyc;

  logic [5:0]  bx_q [$];
  logic [5:0]  by_q [$];
  bit          bn_q [$];
  logic [15:0] exp_q [$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (ovf === 1'b1) ovf_seen++;

  cluster_frame_tx #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .s_y(s_y), .s_null(s_null), .s_last(s_last), .s_evt_id(s_evt_id),
    .fiber(fiber),
    .fxch00(fxch00), .fxch01(fxch01), .fxch02(fxch02), .fxch03(fxch03),
    .fxch04(fxch04), .fxch05(fxch05), .fxch06(fxch06), .fxch07(fxch07),
    .fxch08(fxch08), .fxch09(fxch09), .fxch10(fxch10), .fxch11(fxch11),
    .fxch12(fxch12), .fxch13(fxch13), .fxch14(fxch14), .fxch15(fxch15),
    .ovf(ovf), .dbg_state(dbg_state)
  );

  assign fx[0]  = fxch00; assign fx[1]  = fxch01; assign fx[2]  = fxch02; assign fx[3]  = fxch03;
  assign fx[4]  = fxch04; assign fx[5]  = fxch05; assign fx[6]  = fxch06; assign fx[7]  = fxch07;
  assign fx[8]  = fxch08; assign fx[9]  = fxch09; assign fx[10] = fxch10; assign fx[11] = fxch11;
  assign fx[12] = fxch12; assign fx[13] = fxch13; assign fx[14] = fxch14; assign fx[15] = fxch15;

  function automatic bit fx_zero();
    for (int c = 0; c < 16; c++) if (fx[c] !== 16'h0000) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_beats();
    bx_q.delete(); by_q.delete(); bn_q.delete();
  endtask

  task automatic add_beat(input logic [5:0] x, input logic [5:0] y, input bit nul);
    bx_q.push_back(x); by_q.push_back(y); bn_q.push_back(nul);
  endtask

  // Reference: hits fill slots 0..255 in arrival order, the rest are dropped.
  task automatic build_expected(output int exp_drops);
    int k;
    k = 0;
    exp_q.delete();
    foreach (bx_q[i]) begin
      if (!bn_q[i]) begin
        if (k < 256) exp_q.push_back({4'b0001, bx_q[i], by_q[i]});
        k++;
      end
    end
    while (exp_q.size() < 256) exp_q.push_back(16'h0000);
    exp_drops = (k > 256) ? k - 256 : 0;
  endtask

  // Returns in the drive phase of the cycle after the s_last beat was accepted.
  task automatic send_event(input logic [9:0] evt, input bit bubbles);
    bit accepted;
    int budget;
    not_ready_cnt = 0;
    foreach (bx_q[i]) begin
      if (bubbles && $urandom_range(0, 3) == 0) begin
        s_valid  = 1'b0;
        s_x      = 6'($urandom);
        s_y      = 6'($urandom);
        s_null   = 1'($urandom);
        s_last   = 1'($urandom);
        s_evt_id = 10'($urandom);
        step();
      end
      s_valid  = 1'b1;
      s_x      = bx_q[i];
      s_y      = by_q[i];
      s_null   = bn_q[i];
      s_last   = (i == bx_q.size() - 1);
      s_evt_id = (i == bx_q.size() - 1) ? evt : 10'($urandom);
      accepted = 1'b0;
      budget   = 0;
      while (!accepted) begin
        @(negedge clk);
        if (s_ready === 1'b1) accepted = 1'b1;
        else not_ready_cnt++;
        step();
        budget++;
        if (!accepted && budget > 200) begin
          checks++;
          failures++;
          $display("FAIL send_timeout beat=%0d s_ready=%b expected=1", i, s_ready);
          break;
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_null  = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_frame(input string tag, input logic [9:0] evt, input bit full);
    logic [15:0] e;
    int bad_ch;
    logic [15:0] bad_got, bad_exp;
    @(negedge clk);
    last_sync_cyc = cyc;
    checks++;
    if (fiber !== 16'hAAAA || s_ready !== 1'b0 || !fx_zero()) begin
      failures++;
      $display("FAIL %s_sync fiber=%h s_ready=%b fx00=%h expected fiber=aaaa s_ready=0 fx=0",
               tag, fiber, s_ready, fx[0]);
    end
    for (int b = 0; b < 16; b++) begin
      step();
      @(negedge clk);
      bad_ch = -1;
      bad_got = '0;
      bad_exp = '0;
      for (int c = 0; c < 16; c++) begin
        e = exp_q.pop_front();
        if (fx[c] !== e && bad_ch < 0) begin
          bad_ch = c; bad_got = fx[c]; bad_exp = e;
        end
      end
      checks++;
      if (bad_ch >= 0 || fiber !== 16'h0000) begin
        failures++;
        $display("FAIL %s_beat b=%0d ch=%0d got=%h exp=%h fiber=%h exp_fiber=0000",
                 tag, b, bad_ch, bad_got, bad_exp, fiber);
      end
    end
    step();
    @(negedge clk);
    checks++;
    if (fiber !== {6'b0, evt} || !fx_zero() || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_trailer fiber=%h exp=%h s_ready=%b fx_zero=%b",
               tag, fiber, {6'b0, evt}, s_ready, fx_zero());
    end
    if (full) begin
      for (int g = 0; g < GAP; g++) begin
        step();
        @(negedge clk);
        checks++;
        if (fiber !== 16'h0000 || s_ready !== 1'b0 || !fx_zero()) begin
          failures++;
          $display("FAIL %s_gap g=%0d fiber=%h s_ready=%b expected fiber=0000 s_ready=0",
                   tag, g, fiber, s_ready);
        end
      end
      step();
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b1 || fiber !== 16'h0000) begin
        failures++;
        $display("FAIL %s_ready_again s_ready=%b fiber=%h expected s_ready=1 fiber=0000",
                 tag, s_ready, fiber);
      end
      step();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_last = 1'b1; s_null = 1'b0;
    s_x = 6'd3; s_y = 6'd4; s_evt_id = 10'd9;
    repeat (3) step();
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    checks++;
    if (fiber !== 16'h0000) begin
      failures++; $display("FAIL reset_fiber got=%h exp=0000", fiber);
    end
    checks++;
    if (!fx_zero()) begin
      failures++; $display("FAIL reset_fx got_fx00=%h exp=all zero", fx[0]);
    end
    checks++;
    if (ovf !== 1'b0) begin
      failures++; $display("FAIL reset_ovf got=%b exp=0", ovf);
    end
    checks++;
    if (s_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b exp=1", s_ready);
    end
    step();
  endtask

  task automatic test_single_hit();
    int d;
    clear_beats();
    add_beat(6'd5, 6'd9, 1'b0);
    build_expected(d);
    checks++;
    if (exp_q[0] !== 16'h1149) begin
      failures++; $display("FAIL single_model_word got=%h exp=1149", exp_q[0]);
    end
    send_event(10'h155, 1'b0);
    check_frame("single", 10'h155, 1'b1);
  endtask

  task automatic test_empty();
    int d;
    clear_beats();
    add_beat(6'd21, 6'd33, 1'b1);
    build_expected(d);
    send_event(10'd3, 1'b0);
    check_frame("empty", 10'd3, 1'b1);
  endtask

  task automatic test_17_hits();
    int d;
    clear_beats();
    for (int i = 0; i < 17; i++) add_beat(6'(i), 6'd7, 1'b0);
    build_expected(d);
    send_event(10'h2A5, 1'b1);
    check_frame("hits17", 10'h2A5, 1'b1);
  endtask

  task automatic test_random_events();
    int d;
    int n;
    logic [9:0] evt;
    for (int e = 0; e < 4; e++) begin
      clear_beats();
      n = $urandom_range(1, 60);
      for (int i = 0; i < n; i++)
        add_beat(6'($urandom), 6'($urandom), ($urandom_range(0, 3) == 0));
      build_expected(d);
      evt = 10'($urandom);
      send_event(evt, 1'b1);
      check_frame("random", evt, 1'b1);
    end
  endtask

  task automatic test_overflow();
    int drops;
    int ovf_start;
    clear_beats();
    for (int i = 0; i < 300; i++) add_beat(6'($urandom), 6'($urandom), 1'b0);
    build_expected(drops);
    ovf_start = ovf_seen;
    send_event(10'h3FF, 1'b0);
    check_frame("ovf", 10'h3FF, 1'b1);
    checks++;
    if (ovf_seen - ovf_start !== drops || drops != 44) begin
      failures++;
      $display("FAIL ovf_pulses got=%0d exp=44", ovf_seen - ovf_start);
    end
    checks++;
    if (not_ready_cnt != 0) begin
      failures++;
      $display("FAIL ovf_ready_hold not_ready_cycles=%0d exp=0", not_ready_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    int first_sync;
    clear_beats();
    for (int i = 0; i < 40; i++) add_beat(6'($urandom), 6'($urandom), 1'b0);
    build_expected(d);
    send_event(10'h0AB, 1'b0);
    check_frame("b2b_first", 10'h0AB, 1'b0);
    first_sync = last_sync_cyc;
    clear_beats();
    add_beat(6'd62, 6'd1, 1'b0);
    add_beat(6'd0, 6'd0, 1'b1);
    build_expected(d);
    send_event(10'h1CD, 1'b0);
    check_frame("b2b_second", 10'h1CD, 1'b1);
    checks++;
    if (last_sync_cyc - first_sync < 20) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d exp>=20", last_sync_cyc - first_sync);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d;
    int trailer_seen;
    clear_beats();
    for (int i = 0; i < 100; i++) add_beat(6'($urandom), 6'($urandom), 1'b0);
    build_expected(d);
    send_event(10'h222, 1'b0);
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fiber !== 16'h0000 || !fx_zero() || ovf !== 1'b0 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_outputs fiber=%h fx00=%h ovf=%b s_ready=%b expected 0/0/0/1",
               fiber, fx[0], ovf, s_ready);
    end
    trailer_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      @(negedge clk);
      if (fiber !== 16'h0000 || !fx_zero() || s_ready !== 1'b1) trailer_seen++;
    end
    checks++;
    if (trailer_seen != 0) begin
      failures++;
      $display("FAIL midrst_idle active_cycles=%0d exp=0", trailer_seen);
    end
    step();
    clear_beats();
    add_beat(6'd10, 6'd20, 1'b0);
    add_beat(6'd11, 6'd21, 1'b0);
    add_beat(6'd12, 6'd22, 1'b0);
    build_expected(d);
    send_event(10'h0F0, 1'b1);
    check_frame("midrst_next", 10'h0F0, 1'b1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; s_valid = 1'b0; s_x = '0; s_y = '0; s_null = 1'b0;
    s_last = 1'b0; s_evt_id = '0;
    test_reset();
    test_single_hit();
    test_empty();
    test_17_hits();
    test_random_events();
    test_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cluster_frame_tx.md
CLUSTER_FRAME_TX -- requirements
Module: cluster_frame_tx

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2, meaning the number of idle cycles after the trailer word (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port s_valid, input, 1 bit: a hit-stream beat is offered.
REQ-005 SHALL have port s_ready, output, 1 bit: the block accepts the beat.
REQ-006 SHALL have port s_x, input, 6 bits: hit x coordinate, 0-based.
REQ-007 SHALL have port s_y, input, 6 bits: hit y coordinate, 0-based.
REQ-008 SHALL have port s_null, input, 1 bit: the beat carries no hit (used for empty events).
REQ-009 SHALL have port s_last, input, 1 bit: last beat of the event.
REQ-010 SHALL have port s_evt_id, input, 10 bits: event id, sampled on the accepted s_last beat.
REQ-011 SHALL have port fiber, output, 16 bits: framing lane.
REQ-012 SHALL have ports fxch00..fxch15, output, 16 bits each: per-channel hit words.
REQ-013 SHALL have port ovf, output, 1 bit: one-cycle pulse when a hit is dropped.

Function
REQ-014 Handshake: a beat SHALL transfer when s_valid and s_ready are both high; s_ready SHALL be high only in state COLLECT.
REQ-015 In COLLECT, each accepted non-null beat SHALL store hit word {3'b000, 1'b1, s_x, s_y} at slot index n (0..255), where n is the running hit count; n then increments.
REQ-016 Slot n SHALL map to channel n mod 16 and data beat n div 16.
REQ-017 Coordinates SHALL be transmitted unmodified; the far end adds the +1 offset.
REQ-018 Hits beyond 256 SHALL be accepted and dropped; ovf SHALL pulse for each dropped hit; the count SHALL saturate at 256.
REQ-019 A beat with s_null=1 SHALL store nothing; s_last with s_null=1 SHALL still close the event, so a zero-hit event sends a full frame.
REQ-020 States SHALL be COLLECT -> SYNC -> DATA (16 cycles) -> TRAIL -> GAP (GAP_CYCLES cycles) -> COLLECT.
REQ-021 The transition COLLECT -> SYNC SHALL occur on the cycle after the s_last beat is accepted.
REQ-022 Output timing, with s_last accepted in cycle N:
- fiber = 16'hAAAA in cycle N+1;
- data beats b = 0..15 in cycles N+2..N+17;
- fiber = {6'b0, evt_id} in cycle N+18;
- s_ready high again in cycle N+19+GAP_CYCLES.
REQ-023 During data beat b, fxchCC SHALL carry slot b*16+CC if that slot was filled, else 16'h0000.
REQ-024 fiber SHALL be 16'h0000 in every cycle other than SYNC and TRAIL.
REQ-025 fxch00..15 SHALL be 16'h0000 in every cycle other than DATA.
REQ-026 fiber SHALL never equal 16'hAAAA outside SYNC.
REQ-027 All outputs SHALL be registered.
REQ-028 The slot valid bits and the hit count SHALL clear in GAP, so stale hits never leak into the next frame.
REQ-029 s_x, s_y, s_null and s_evt_id SHALL be ignored when no transfer occurs.

Reset
REQ-030 On rst, the block SHALL enter COLLECT, clear the hit count and all slot valid bits, and drive fiber=0, fxch00..15=0, ovf=0 and s_ready=1 in the following cycle.
REQ-031 rst asserted mid-frame SHALL abort the frame with no trailer sent; the next frame starts only after a new s_last.
REQ-032 Slot data storage need not be reset; only the slot valid bits SHALL be reset.

Structure
REQ-033 Shared package SHALL hold:
- SYNC_WORD = 16'hAAAA;
- NCH = 16; NBEAT = 16; MAX_HITS = 256;
- the state enumeration;
- the hit-word field positions (c = bit 12, x = [11:6], y = [5:0]).
REQ-034 Sub-module hit_slot_bank SHALL implement the 16 banks x 16 entries x 13-bit storage: one write port addressed by slot index, one 16-wide read port addressed by beat, and a valid-bit array with bulk clear.

Verification
REQ-035 Single hit (x=5, y=9), s_last, evt_id=0x155 -> fiber AAAA at N+1; fxch00=16'h1149 at N+2; all other channel words 0; fiber=16'h0155 at N+18.
REQ-036 Empty event (s_null=1, s_last, evt_id=3) -> SYNC word, 16 all-zero data beats, fiber=16'h0003, then gap.
REQ-037 17 hits with y=7, x=0..16 -> beat 0 fxch00..15 carry x=0..15; beat 1 fxch00 carries x=16; everything else 0.
REQ-038 300 hits -> 256 slots filled, ovf pulses exactly 44 times, s_ready stays high until s_last.
REQ-039 Two back-to-back events with GAP_CYCLES=1 -> second SYNC at least 20 cycles after the first; second frame contains no hits from the first.
REQ-040 rst at data beat 5 -> next cycle all outputs 0 and s_ready=1; no trailer emitted; the following event frames normally.
